// File: rtl/run_length_detector.sv
// Run-length detector: flags runs of run_len equal samples on serial input w,
// with polarity selection, overlap/restart modes, sample enable and a hit counter.
module run_length_detector #(
  parameter int RUN_W = 4,
  parameter int HIT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             w,
  input  logic [RUN_W-1:0] run_len,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_bit,
  output logic [RUN_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN0 = 2'd1;
  localparam logic [1:0] RUN1 = 2'd2;

  localparam logic [RUN_W-1:0] CNT_MAX = {RUN_W{1'b1}};
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  logic [1:0]       state, state_nxt;
  logic [RUN_W-1:0] cnt_inc, cnt_nxt, thr;
  logic             same_run, pol_en, hit;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = run_cnt;
    cnt_inc   = '0;
    same_run  = 1'b0;
    pol_en    = 1'b0;
    hit       = 1'b0;
    thr       = (run_len == '0) ? RUN_W'(1) : run_len;

    same_run = (state == RUN0 && !w) || (state == RUN1 && w);
    if (!same_run)
      cnt_inc = RUN_W'(1);
    else if (run_cnt == CNT_MAX)
      cnt_inc = CNT_MAX;
    else
      cnt_inc = run_cnt + RUN_W'(1);

    pol_en = w ? mode[1] : mode[0];

    if (en) begin
      state_nxt = w ? RUN1 : RUN0;
      hit       = pol_en && (overlap ? (cnt_inc >= thr) : (cnt_inc == thr));
      // Restart mode: a completed run starts over, polarity is kept.
      cnt_nxt   = (hit && !overlap) ? '0 : cnt_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_cnt <= '0;
      z       <= 1'b0;
      z_bit   <= 1'b0;
      hit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= cnt_nxt;
      z       <= hit;
      if (hit)
        z_bit <= w;
      if (clr_cnt)
        hit_cnt <= '0;
      else if (hit && hit_cnt != HIT_MAX)
        hit_cnt <= hit_cnt + HIT_W'(1);
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Directed self-checking bench for run_length_detector with hand-computed vectors.
module tb_run_length_detector;

  logic        clk = 1'b0;
  logic        rst_n, en, w, overlap, clr_cnt;
  logic [3:0]  run_len;
  logic [1:0]  mode;
  logic        z, z_bit;
  logic [3:0]  run_cnt;
  logic [15:0] hit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  run_length_detector #(.RUN_W(4), .HIT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .run_len(run_len),
    .mode(mode), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z), .z_bit(z_bit), .run_cnt(run_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Apply one sample, clock it, then check z and run_cnt after the edge.
  task automatic step(input string tag, input logic wv, input logic ev,
                      input logic ez, input int ecnt);
    w = wv; en = ev;
    @(posedge clk); #1;
    check({tag, ".z"}, 32'(z), 32'(ez));
    check({tag, ".cnt"}, 32'(run_cnt), 32'(ecnt));
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; w = 1'b0; overlap = 1'b1; clr_cnt = 1'b0;
    run_len = 4'd2; mode = 2'b11;

    // Reset state
    do_reset();
    check("rst.z", 32'(z), 0);
    check("rst.zbit", 32'(z_bit), 0);
    check("rst.cnt", 32'(run_cnt), 0);
    check("rst.hits", 32'(hit_cnt), 0);

    // 1: legacy 00/11 behaviour
    step("t1s1", 0, 1, 0, 1);
    step("t1s2", 0, 1, 1, 2);
    check("t1.zbit_a", 32'(z_bit), 0);
    step("t1s3", 1, 1, 0, 1);
    check("t1.zbit_hold", 32'(z_bit), 0);
    step("t1s4", 1, 1, 1, 2);
    check("t1.zbit_b", 32'(z_bit), 1);
    step("t1s5", 1, 1, 1, 3);
    step("t1s6", 0, 1, 0, 1);
    check("t1.zbit_c", 32'(z_bit), 1);
    check("t1.hits", 32'(hit_cnt), 3);

    // 2: restart mode, runs of 1
    do_reset();
    run_len = 4'd3; mode = 2'b10; overlap = 1'b0;
    step("t2s1", 1, 1, 0, 1);
    step("t2s2", 1, 1, 0, 2);
    step("t2s3", 1, 1, 1, 0);
    step("t2s4", 1, 1, 0, 1);
    step("t2s5", 1, 1, 0, 2);
    step("t2s6", 1, 1, 1, 0);
    step("t2s7", 1, 1, 0, 1);
    check("t2.hits", 32'(hit_cnt), 2);

    // 3: enable gaps are invisible to the run (w toggles while ignored)
    do_reset();
    run_len = 4'd2; mode = 2'b01; overlap = 1'b1;
    step("t3s1", 0, 1, 0, 1);
    step("t3g1", 1, 0, 0, 1);
    step("t3g2", 1, 0, 0, 1);
    step("t3g3", 1, 0, 0, 1);
    step("t3s2", 0, 1, 1, 2);
    check("t3.hits", 32'(hit_cnt), 1);

    // 4: maximum threshold with counter saturation
    do_reset();
    run_len = 4'd15; mode = 2'b10; overlap = 1'b1;
    for (int i = 1; i <= 20; i++)
      step($sformatf("t4s%0d", i), 1, 1, (i >= 15), (i > 15) ? 15 : i);
    check("t4.hits", 32'(hit_cnt), 6);

    // 5: run_len=0 acts as 1; disabled polarity and mode 00 never hit
    do_reset();
    run_len = 4'd0; mode = 2'b11; overlap = 1'b1;
    step("t5s1", 1, 1, 1, 1);
    step("t5s2", 1, 1, 1, 2);
    step("t5s3", 0, 1, 1, 1);
    check("t5.zbit", 32'(z_bit), 0);
    mode = 2'b00;
    step("t5m0a", 0, 1, 0, 2);
    step("t5m0b", 0, 1, 0, 3);
    step("t5m0c", 0, 1, 0, 4);
    mode = 2'b01;
    step("t5pol", 1, 1, 0, 1);
    check("t5.hits", 32'(hit_cnt), 3);
    check("t5.zbit_hold", 32'(z_bit), 0);

    // 6: mid-run reset, then clear racing a hit
    do_reset();
    run_len = 4'd3; mode = 2'b10; overlap = 1'b1;
    for (int i = 1; i <= 5; i++)
      step($sformatf("t6s%0d", i), 1, 1, (i >= 3), i);
    check("t6.hits_pre", 32'(hit_cnt), 3);
    w = 1'b1; en = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6.rst.z", 32'(z), 0);
    check("t6.rst.zbit", 32'(z_bit), 0);
    check("t6.rst.cnt", 32'(run_cnt), 0);
    check("t6.rst.hits", 32'(hit_cnt), 0);
    step("t6r1", 1, 1, 0, 1);
    run_len = 4'd1;
    step("t6r2", 1, 1, 1, 2);
    check("t6.hits_a", 32'(hit_cnt), 1);
    clr_cnt = 1'b1;
    step("t6clr", 1, 1, 1, 3);
    check("t6.clr_wins", 32'(hit_cnt), 0);
    clr_cnt = 1'b0;
    step("t6r3", 1, 1, 1, 4);
    check("t6.hits_b", 32'(hit_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
